// File: rtl/clock_time_counter.sv
// clock_time_counter: BCD hh:mm:ss time-of-day counter driven by a synchronised one-second strobe
//   CLK_50     50 MHz clock; every state update happens on its rising edge
//   reset_en   synchronous active-high reset; clears the time, pulses and synchroniser
//   run_en     1 = count detected seconds, 0 = hold the time
//   sec_clk    untrusted one-second level from the divider
//   load_valid request to load set_hour/set_min/set_sec (BCD)
//   hour_bcd/min_bcd/sec_bcd  registered BCD time
//   tick/hour_pulse/day_pulse one-cycle pulses on a counted second / 59:59 wrap / 23:59:59 wrap
//   load_ack/load_err         one-cycle pulses: load accepted / load rejected
module clock_time_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK_50,
  input  logic       reset_en,
  input  logic       run_en,
  input  logic       sec_clk,
  input  logic       load_valid,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       tick,
  output logic       hour_pulse,
  output logic       day_pulse,
  output logic       load_ack,
  output logic       load_err
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_prev;
  logic [3:0] r_h1, r_h0, r_m1, r_m0, r_s1, r_s0;
  logic r_tick, r_hour_pulse, r_day_pulse, r_load_ack, r_load_err;
  logic w_edge, w_count, w_load_ok;
  logic w_s0_w, w_s_w, w_m0_w, w_m_w, w_h0_w, w_h_w;
  // the edge detector runs independently of run_en so re-enabling never sees a stale edge
  assign w_edge  = r_sync[SYNC_STAGES-1] & ~r_prev;
  // a coincident load takes priority and swallows the second
  assign w_count = w_edge & run_en & ~load_valid;
  // digits must be decimal; hours tens may exceed 1 only as 20..23
  assign w_load_ok = set_hour[3:0] <= 4'd9 && set_min[3:0] <= 4'd9 && set_sec[3:0] <= 4'd9 &&
                     set_min[7:4] <= 4'd5 && set_sec[7:4] <= 4'd5 &&
                     (set_hour[7:4] < 4'd2 || (set_hour[7:4] == 4'd2 && set_hour[3:0] <= 4'd3));
  // ripple-carry wrap conditions, each one implies all lower digits also wrap
  assign w_s0_w = r_s0 == 4'd9;
  assign w_s_w  = w_s0_w & (r_s1 == 4'd5);
  assign w_m0_w = w_s_w & (r_m0 == 4'd9);
  assign w_m_w  = w_m0_w & (r_m1 == 4'd5);
  assign w_h0_w = w_m_w & (r_h0 == 4'd9);
  assign w_h_w  = w_m_w & (r_h1 == 4'd2) & (r_h0 == 4'd3);
  always_ff @(posedge CLK_50) begin
    if (reset_en) begin
      r_sync       <= '0;
      r_prev       <= 1'b0;
      {r_h1, r_h0, r_m1, r_m0, r_s1, r_s0} <= '0;
      r_tick       <= 1'b0;
      r_hour_pulse <= 1'b0;
      r_day_pulse  <= 1'b0;
      r_load_ack   <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], sec_clk};
      r_prev       <= r_sync[SYNC_STAGES-1];
      r_tick       <= w_count;
      r_hour_pulse <= w_count & w_m_w;
      r_day_pulse  <= w_count & w_h_w;
      r_load_ack   <= load_valid & w_load_ok;
      r_load_err   <= load_valid & ~w_load_ok;
      if (load_valid) begin
        if (w_load_ok)
          {r_h1, r_h0, r_m1, r_m0, r_s1, r_s0} <= {set_hour, set_min, set_sec};
      end else if (w_count) begin
        r_s0 <= w_s0_w ? 4'd0 : r_s0 + 4'd1;
        if (w_s0_w) r_s1 <= w_s_w ? 4'd0 : r_s1 + 4'd1;
        if (w_s_w) r_m0 <= w_m0_w ? 4'd0 : r_m0 + 4'd1;
        if (w_m0_w) r_m1 <= w_m_w ? 4'd0 : r_m1 + 4'd1;
        if (w_m_w) begin
          r_h0 <= (w_h_w | w_h0_w) ? 4'd0 : r_h0 + 4'd1;
          r_h1 <= w_h_w ? 4'd0 : w_h0_w ? r_h1 + 4'd1 : r_h1;
        end
      end
    end
  end
  assign hour_bcd   = {r_h1, r_h0};
  assign min_bcd    = {r_m1, r_m0};
  assign sec_bcd    = {r_s1, r_s0};
  assign tick       = r_tick;
  assign hour_pulse = r_hour_pulse;
  assign day_pulse  = r_day_pulse;
  assign load_ack   = r_load_ack;
  assign load_err   = r_load_err;
endmodule

// File: tb/tb_clock_time_counter.sv
// tb_clock_time_counter: directed and random checks of clock_time_counter against a seconds-of-day model
module tb_clock_time_counter;
  localparam int S = 2;
  logic CLK_50 = 1'b0;
  logic reset_en = 1'b1, run_en = 1'b0, sec_clk = 1'b0, load_valid = 1'b0;
  logic [7:0] set_hour = '0, set_min = '0, set_sec = '0;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic tick, hour_pulse, day_pulse, load_ack, load_err;
  int n_vec = 0, n_err = 0, tick_cnt = 0;
  int tod = 0;
  bit q[$];
  bit e_tick, e_hp, e_dp, e_ack, e_err;
  clock_time_counter #(.SYNC_STAGES(S)) dut (
    .CLK_50(CLK_50), .reset_en(reset_en), .run_en(run_en), .sec_clk(sec_clk),
    .load_valid(load_valid), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .tick(tick),
    .hour_pulse(hour_pulse), .day_pulse(day_pulse), .load_ack(load_ack), .load_err(load_err)
  );
  always #5 CLK_50 = ~CLK_50;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction
  function automatic bit time_ok(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    if (h[3:0] > 9 || m[3:0] > 9 || s[3:0] > 9 || h[7:4] > 9) return 0;
    return from_bcd(h) <= 23 && from_bcd(m) <= 59 && from_bcd(s) <= 59;
  endfunction
  // one clock: the model consumes the inputs seen at the edge, then every output is compared
  task automatic step();
    int n;
    bit cur, prv, ok;
    @(posedge CLK_50);
    {e_tick, e_hp, e_dp, e_ack, e_err} = '0;
    if (reset_en) begin
      tod = 0;
      q.delete();
    end else begin
      n = q.size();
      cur = n >= S ? q[n-S] : 1'b0;
      prv = n >= S + 1 ? q[n-S-1] : 1'b0;
      q.push_back(sec_clk);
      if (load_valid) begin
        ok = time_ok(set_hour, set_min, set_sec);
        if (ok) tod = from_bcd(set_hour) * 3600 + from_bcd(set_min) * 60 + from_bcd(set_sec);
        e_ack = ok;
        e_err = !ok;
      end else if (run_en && cur && !prv) begin
        e_tick = 1;
        e_hp = (tod % 3600) == 3599;
        e_dp = tod == 86399;
        tod = (tod + 1) % 86400;
      end
    end
    #1;
    if (tick === 1'b1) tick_cnt++;
    chk("hour", hour_bcd, to_bcd(tod / 3600));
    chk("min", min_bcd, to_bcd((tod / 60) % 60));
    chk("sec", sec_bcd, to_bcd(tod % 60));
    chk("tick", {7'd0, tick}, {7'd0, e_tick});
    chk("hour_pulse", {7'd0, hour_pulse}, {7'd0, e_hp});
    chk("day_pulse", {7'd0, day_pulse}, {7'd0, e_dp});
    chk("load_ack", {7'd0, load_ack}, {7'd0, e_ack});
    chk("load_err", {7'd0, load_err}, {7'd0, e_err});
  endtask
  task automatic sec_pulse(input int hi, input int lo);
    sec_clk = 1;
    repeat (hi) step();
    sec_clk = 0;
    repeat (lo) step();
  endtask
  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load_valid = 1;
    {set_hour, set_min, set_sec} = {h, m, s};
    step();
    load_valid = 0;
  endtask
  initial begin
    int hp_cnt, dp_cnt, t, len;
    step();
    chk("reset_time", {hour_bcd, min_bcd, sec_bcd} == 24'h0 ? 8'd1 : 8'd0, 8'd1);
    reset_en = 0;
    run_en = 1;
    repeat (3) step();
    tick_cnt = 0;
    repeat (5) sec_pulse(20, 20);
    chk("five_secs", sec_bcd, 8'h05);
    chk("five_ticks", 8'(tick_cnt), 8'd5);
    do_load(8'h23, 8'h59, 8'h58);
    chk("ack_235958", {7'd0, load_ack}, 8'd1);
    hp_cnt = 0;
    dp_cnt = 0;
    repeat (2) begin
      sec_clk = 1;
      repeat (20) begin
        step();
        hp_cnt += int'(hour_pulse);
        dp_cnt += int'(day_pulse);
      end
      sec_clk = 0;
      repeat (20) step();
    end
    chk("midnight", sec_bcd | min_bcd | hour_bcd, 8'h00);
    chk("hp_once", 8'(hp_cnt), 8'd1);
    chk("dp_once", 8'(dp_cnt), 8'd1);
    do_load(8'h24, 8'h00, 8'h00);
    chk("err_hour24", {7'd0, load_err}, 8'd1);
    do_load(8'h12, 8'h5A, 8'h00);
    chk("err_min5a", {7'd0, load_err}, 8'd1);
    chk("unchanged", hour_bcd | min_bcd | sec_bcd, 8'h00);
    do_load(8'h08, 8'h59, 8'h59);
    sec_clk = 1;
    step();
    step();
    load_valid = 1;
    {set_hour, set_min, set_sec} = {8'h09, 8'h00, 8'h00};
    step();
    load_valid = 0;
    chk("align_hour", hour_bcd, 8'h09);
    chk("align_tick", {7'd0, tick}, 8'd0);
    chk("align_hp", {7'd0, hour_pulse}, 8'd0);
    repeat (20) step();
    sec_clk = 0;
    repeat (20) step();
    chk("align_sec", sec_bcd, 8'h00);
    run_en = 0;
    repeat (3) sec_pulse(20, 20);
    sec_clk = 1;
    repeat (5) step();
    run_en = 1;
    repeat (15) step();
    sec_clk = 0;
    repeat (20) step();
    chk("held_sec", sec_bcd, 8'h00);
    sec_pulse(20, 20);
    chk("resumed_sec", sec_bcd, 8'h01);
    do_load(8'h00, 8'h12, 8'h34);
    reset_en = 1;
    step();
    reset_en = 0;
    chk("reset_mid", min_bcd | sec_bcd, 8'h00);
    step();
    for (int i = 0; i < 400; i++) begin
      len = $urandom_range(1, 12);
      sec_clk = ~sec_clk;
      run_en = $urandom_range(0, 9) != 0;
      for (int j = 0; j < len; j++) begin
        reset_en = $urandom_range(0, 299) == 0;
        load_valid = $urandom_range(0, 29) == 0;
        if ($urandom_range(0, 2) == 0) begin
          {set_hour, set_min, set_sec} = 24'($urandom);
        end else begin
          t = $urandom_range(0, 1) ? $urandom_range(86380, 86399) : $urandom_range(0, 86399);
          if ($urandom_range(0, 1)) t = t - t % 3600 + 3590 + $urandom_range(0, 9);
          {set_hour, set_min, set_sec} = {to_bcd(t / 3600), to_bcd((t / 60) % 60), to_bcd(t % 60)};
        end
        step();
      end
    end
    reset_en = 0;
    load_valid = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
